// File: rtl/io_out_queue_pkg.sv
// Shared sizing for the IO-side output buffers: default geometry and pointer width helper.
package io_out_queue_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;

  // Pointers carry one extra wrap bit above the index so full and empty can be told apart.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef logic [ptr_w(DEFAULT_DEPTH)-1:0] ptr_t;

endpackage

// File: rtl/veryl_Decoupled.sv
// Decoupled valid/ready channel: the sender drives valid and bits, the receiver drives ready.
interface veryl_Decoupled #(
  parameter int WIDTH = 8
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] bits;

  modport sender   (output valid, output bits, input ready);
  modport receiver (input valid, input bits, output ready);
endinterface

// File: rtl/io_out_queue_mem.sv
// Queue storage: DEPTH x WIDTH registers, one write port and one asynchronous read port.
module io_out_queue_mem
  import io_out_queue_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/io_out_queue.sv
// Elastic FIFO between the IO-write path and an output peripheral's Decoupled receiver.
// Define IO_OUT_QUEUE_BYPASS_EN to let a word pass straight through when the queue is empty.
module io_out_queue
  import io_out_queue_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  veryl_Decoupled.receiver       if_din,
  veryl_Decoupled.sender         if_dout,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] ONE = PW'(1);

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    count;
  logic [WIDTH-1:0] rdata;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  // Ready depends only on occupancy, never on the downstream ready.
  assign if_din.ready = !full;
  assign pop          = !empty && if_dout.ready;

`ifdef IO_OUT_QUEUE_BYPASS_EN
  logic bypass;

  // A word that leaves in the same cycle it arrives at an empty queue is never stored.
  assign bypass        = empty && if_din.valid && if_dout.ready;
  assign push          = if_din.valid && !full && !bypass;
  assign if_dout.valid = empty ? if_din.valid : 1'b1;
  assign if_dout.bits  = empty ? if_din.bits : rdata;
`else
  assign push          = if_din.valid && !full;
  assign if_dout.valid = !empty;
  assign if_dout.bits  = empty ? '0 : rdata;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ONE;
      if (pop)  rd_ptr <= rd_ptr + ONE;
      case ({push, pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end

  io_out_queue_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .i_clk (i_clk),
    .we    (push),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (if_din.bits),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rdata)
  );

  assign o_count = count;
  assign o_full  = full;
  assign o_empty = empty;

endmodule
